// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    // Number of bitstream words needed to cover the whole chain.
    function automatic int unsigned words_per_load(input int unsigned chain_len,
                                                   input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Parallel-in / serial-out word buffer, MSB first, with a ready look-ahead
// so that a new word can be loaded on the edge that consumes the last bit.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              room_i,
    input  logic              shift_i,
    input  logic              valid_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              ready_o,
    output logic              accept_o,
    output logic              avail_o,
    output logic              bit_o
);

    localparam int unsigned BITS_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [BITS_W-1:0] word_bits_q, word_bits_d;

    assign avail_o  = (word_bits_q != '0);
    assign bit_o    = sreg_q[WORD_W-1];
    assign ready_o  = room_i && (!avail_o || ((word_bits_q == BITS_W'(1)) && shift_i));
    assign accept_o = ready_o && valid_i;

    // Next word/remaining-bit state: a load replaces the word whose last bit shifts out now.
    always_comb begin
        sreg_d      = sreg_q;
        word_bits_d = word_bits_q;
        if (clear_i) begin
            word_bits_d = '0;
        end else if (accept_o) begin
            sreg_d      = data_i;
            word_bits_d = BITS_W'(WORD_W);
        end else if (shift_i) begin
            sreg_d      = sreg_q << 1;
            word_bits_d = word_bits_q - BITS_W'(1);
        end
    end

    // Word and bit-count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sreg_q      <= '0;
            word_bits_q <= '0;
        end else begin
            sreg_q      <= sreg_d;
            word_bits_q <= word_bits_d;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Programming-side driver for the configuration chain: serializes bitstream
// words onto ccff_head, gates prog_clk via ccff_clk_en, optionally verifies
// the previous chain contents emerging on ccff_tail.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              verify,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [CNT_W-1:0]  bits_shifted
);

    localparam int unsigned WPL  = words_per_load(CHAIN_LEN, WORD_W);
    localparam int unsigned WA_W = $clog2(WPL + 1);

    state_e            state_q, state_d;
    logic              verify_q, verify_d;
    logic              head_q, head_d;
    logic              en_q, en_d;
    logic              mm_q, mm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WA_W-1:0]   words_q, words_d;

    logic ser_bit, ser_avail, ser_accept;
    logic room, shift, clear, chain_open, last_edge;

    // A bit already registered (en_q) will be captured this edge, so it counts as issued.
    assign chain_open = en_q ? (cnt_q < CNT_W'(CHAIN_LEN - 1)) : (cnt_q < CNT_W'(CHAIN_LEN));
    assign shift      = (state_q == S_RUN) && ser_avail && chain_open;
    assign room       = (state_q == S_RUN) && (words_q < WA_W'(WPL));
    assign clear      = (state_q == S_IDLE) && start;
    assign last_edge  = en_q && (cnt_q == CNT_W'(CHAIN_LEN - 1));

    ccff_word_serializer #(
        .WORD_W(WORD_W)
    ) u_ser (
        .clk_i   (prog_clk),
        .rst_i   (reset),
        .clear_i (clear),
        .room_i  (room),
        .shift_i (shift),
        .valid_i (s_valid),
        .data_i  (s_data),
        .ready_o (s_ready),
        .accept_o(ser_accept),
        .avail_o (ser_avail),
        .bit_o   (ser_bit)
    );

    // FSM next state, bit counter, verify compare and shift output staging.
    always_comb begin
        state_d  = state_q;
        verify_d = verify_q;
        head_d   = head_q;
        en_d     = 1'b0;
        mm_d     = mm_q;
        cnt_d    = cnt_q;
        words_d  = words_q;

        if (en_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (verify_q && (ccff_tail != head_q)) begin
                mm_d = 1'b1;
            end
        end
        if (ser_accept) begin
            words_d = words_q + WA_W'(1);
        end
        if (shift) begin
            head_d = ser_bit;
            en_d   = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    verify_d = verify;
                    cnt_d    = '0;
                    mm_d     = 1'b0;
                    words_d  = '0;
                end
            end
            S_RUN: begin
                if (last_edge) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the enable at once so no edge leaks out.
    always_ff @(posedge prog_clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            verify_q <= 1'b0;
            head_q   <= 1'b0;
            en_q     <= 1'b0;
            mm_q     <= 1'b0;
            cnt_q    <= '0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            verify_q <= verify_d;
            head_q   <= head_d;
            en_q     <= en_d;
            mm_q     <= mm_d;
            cnt_q    <= cnt_d;
            words_q  <= words_d;
        end
    end

    assign ccff_head    = head_q;
    assign ccff_clk_en  = en_q;
    assign busy         = (state_q == S_RUN);
    assign done         = (state_q == S_DONE);
    assign mismatch     = mm_q;
    assign bits_shifted = cnt_q;

endmodule
